// File: rtl/controlador_snooping.sv
// MSI snooping cache-line controller: a small direct-mapped tag/state/data array that sequences
// CPU requests over the bus and memory and services snoops with one shared coherence machine.
module controlador_snooping #(
   parameter int unsigned INDEX_W = 2,
   parameter int unsigned TAG_W   = 4,
   parameter int unsigned DATA_W  = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       cpuValid,
   output logic                       cpuReady,
   input  logic                       cpuWrite,
   input  logic [TAG_W+INDEX_W-1:0]   cpuEndereco,
   input  logic [DATA_W-1:0]          cpuDadoEscrita,
   output logic                       cpuDone,
   output logic [DATA_W-1:0]          cpuDadoLeitura,
   output logic                       maquina,
   output logic [1:0]                 op,
   output logic [1:0]                 estadoAtual,
   output logic [1:0]                 entradaMaquina,
   input  logic [1:0]                 novoEstado,
   input  logic [1:0]                 saidaMaquina,
   input  logic                       writeBack,
   input  logic                       abortAccessMemory,
   output logic                       busReq,
   input  logic                       busGrant,
   output logic                       busValid,
   output logic [1:0]                 busMsg,
   output logic [TAG_W+INDEX_W-1:0]   busEndereco,
   input  logic                       snoopValid,
   input  logic [1:0]                 snoopMsg,
   input  logic [TAG_W+INDEX_W-1:0]   snoopEndereco,
   output logic                       snoopAck,
   output logic                       busAbortOut,
   output logic [DATA_W-1:0]          busDadoSaida,
   input  logic                       busAbortIn,
   input  logic [DATA_W-1:0]          busDadoEntrada,
   output logic                       memReq,
   output logic                       memWrite,
   output logic [TAG_W+INDEX_W-1:0]   memEndereco,
   output logic [DATA_W-1:0]          memDadoEscrita,
   input  logic                       memAck,
   input  logic [DATA_W-1:0]          memDadoLeitura
);

   localparam int unsigned AW     = TAG_W + INDEX_W;
   localparam int unsigned LINHAS = 2 ** INDEX_W;

   localparam logic [1:0] est_invalido   = 2'b00;
   localparam logic [1:0] msg_read_miss  = 2'b01;
   localparam logic [1:0] msg_write_miss = 2'b10;
   localparam logic [1:0] msg_sem        = 2'b11;

   localparam logic [2:0] st_ocioso      = 3'd0;
   localparam logic [2:0] st_consulta    = 3'd1;
   localparam logic [2:0] st_espera_bus  = 3'd2;
   localparam logic [2:0] st_writeback   = 3'd3;
   localparam logic [2:0] st_mensagem    = 3'd4;
   localparam logic [2:0] st_leitura_mem = 3'd5;
   localparam logic [2:0] st_fim         = 3'd6;
   localparam logic [2:0] st_snoop       = 3'd7;

   logic [TAG_W-1:0]  linha_tag_q  [LINHAS];
   logic [1:0]        linha_est_q  [LINHAS];
   logic [DATA_W-1:0] linha_dado_q [LINHAS];

   logic [2:0]        estado_q, estado_d;
   logic [2:0]        retorno_q;
   logic              req_write_q;
   logic [AW-1:0]     req_addr_q;
   logic [DATA_W-1:0] req_dado_q;
   logic [1:0]        novo_q;
   logic [1:0]        msg_q;
   logic              wb_q;
   logic [DATA_W-1:0] dado_lido_q;

   logic [INDEX_W-1:0] req_idx, snp_idx;
   logic [TAG_W-1:0]   req_tag, snp_tag;
   logic               hit, snp_match, aceita, foi_miss;
   logic [DATA_W-1:0]  dado_final;

   assign req_idx   = req_addr_q[INDEX_W-1:0];
   assign req_tag   = req_addr_q[AW-1:INDEX_W];
   assign snp_idx   = snoopEndereco[INDEX_W-1:0];
   assign snp_tag   = snoopEndereco[AW-1:INDEX_W];
   assign hit       = (linha_tag_q[req_idx] == req_tag) && (linha_est_q[req_idx] != est_invalido);
   assign snp_match = (linha_tag_q[snp_idx] == snp_tag);
   assign aceita    = (estado_q == st_ocioso) && !snoopValid && cpuValid;
   assign foi_miss  = (msg_q == msg_read_miss) || (msg_q == msg_write_miss);
   // Writes always store the CPU word; reads keep the fetched word on a miss, else the line.
   assign dado_final = req_write_q ? req_dado_q :
                       (foi_miss ? dado_lido_q : linha_dado_q[req_idx]);

   always_comb begin
      estado_d = estado_q;
      case (estado_q)
         st_ocioso: begin
            if (snoopValid)    estado_d = st_snoop;
            else if (cpuValid) estado_d = st_consulta;
         end
         st_consulta:    estado_d = (saidaMaquina == msg_sem) ? st_fim : st_espera_bus;
         st_espera_bus: begin
            if (snoopValid)    estado_d = st_snoop;
            else if (busGrant) estado_d = wb_q ? st_writeback : st_mensagem;
         end
         st_writeback:   if (memAck) estado_d = st_mensagem;
         st_mensagem:    estado_d = foi_miss ? st_leitura_mem : st_fim;
         st_leitura_mem: if (busAbortIn || memAck) estado_d = st_fim;
         st_fim:         estado_d = st_ocioso;
         st_snoop:       estado_d = retorno_q;
         default:        estado_d = st_ocioso;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado_q    <= st_ocioso;
         retorno_q   <= st_ocioso;
         req_write_q <= 1'b0;
         req_addr_q  <= '0;
         req_dado_q  <= '0;
         novo_q      <= est_invalido;
         msg_q       <= msg_sem;
         wb_q        <= 1'b0;
         dado_lido_q <= '0;
         for (int i = 0; i < LINHAS; i++) begin
            linha_tag_q[i]  <= '0;
            linha_est_q[i]  <= est_invalido;
            linha_dado_q[i] <= '0;
         end
      end else begin
         estado_q <= estado_d;
         if (aceita) begin
            req_write_q <= cpuWrite;
            req_addr_q  <= cpuEndereco;
            req_dado_q  <= cpuDadoEscrita;
         end
         if (estado_q == st_consulta) begin
            novo_q <= novoEstado;
            msg_q  <= saidaMaquina;
            wb_q   <= writeBack;
         end
         // A snoop taken while waiting for the bus may change the line, so re-run the lookup.
         if (estado_q == st_ocioso && snoopValid)     retorno_q <= st_ocioso;
         if (estado_q == st_espera_bus && snoopValid) retorno_q <= st_consulta;
         if (estado_q == st_leitura_mem) begin
            if (busAbortIn)  dado_lido_q <= busDadoEntrada;
            else if (memAck) dado_lido_q <= memDadoLeitura;
         end
         if (estado_q == st_fim) begin
            linha_tag_q[req_idx]  <= req_tag;
            linha_est_q[req_idx]  <= novo_q;
            linha_dado_q[req_idx] <= dado_final;
         end
         if (estado_q == st_snoop && snp_match) linha_est_q[snp_idx] <= novoEstado;
      end
   end

   always_comb begin
      cpuReady       = 1'b0;
      cpuDone        = 1'b0;
      cpuDadoLeitura = '0;
      maquina        = 1'b0;
      op             = 2'b00;
      estadoAtual    = est_invalido;
      entradaMaquina = msg_sem;
      busReq         = 1'b0;
      busValid       = 1'b0;
      busMsg         = msg_sem;
      busEndereco    = '0;
      snoopAck       = 1'b0;
      busAbortOut    = 1'b0;
      busDadoSaida   = '0;
      memReq         = 1'b0;
      memWrite       = 1'b0;
      memEndereco    = '0;
      memDadoEscrita = '0;
      case (estado_q)
         st_ocioso:     cpuReady = !snoopValid;
         st_consulta: begin
            op          = {req_write_q, ~hit};
            estadoAtual = linha_est_q[req_idx];
         end
         st_espera_bus: busReq = !snoopValid;
         st_writeback: begin
            busReq         = 1'b1;
            memReq         = 1'b1;
            memWrite       = 1'b1;
            memEndereco    = {linha_tag_q[req_idx], req_idx};
            memDadoEscrita = linha_dado_q[req_idx];
         end
         st_mensagem: begin
            busReq      = 1'b1;
            busValid    = 1'b1;
            busMsg      = msg_q;
            busEndereco = req_addr_q;
         end
         st_leitura_mem: begin
            busReq      = 1'b1;
            memReq      = !busAbortIn;
            memEndereco = req_addr_q;
         end
         st_fim: begin
            cpuDone        = 1'b1;
            cpuDadoLeitura = dado_final;
         end
         st_snoop: begin
            maquina        = 1'b1;
            entradaMaquina = snoopMsg;
            estadoAtual    = snp_match ? linha_est_q[snp_idx] : est_invalido;
            snoopAck       = 1'b1;
            if (abortAccessMemory) begin
               busAbortOut  = 1'b1;
               busDadoSaida = linha_dado_q[snp_idx];
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_controlador_snooping.sv
// Directed bench for controlador_snooping with a behavioural MSI coherence machine attached.
module tb_controlador_snooping;

   logic       clock, reset;
   logic       cpuValid, cpuReady, cpuWrite, cpuDone;
   logic [5:0] cpuEndereco;
   logic [7:0] cpuDadoEscrita, cpuDadoLeitura;
   logic       maquina;
   logic [1:0] op, estadoAtual, entradaMaquina, novoEstado, saidaMaquina;
   logic       writeBack, abortAccessMemory;
   logic       busReq, busGrant, busValid;
   logic [1:0] busMsg;
   logic [5:0] busEndereco;
   logic       snoopValid, snoopAck;
   logic [1:0] snoopMsg;
   logic [5:0] snoopEndereco;
   logic       busAbortOut, busAbortIn;
   logic [7:0] busDadoSaida, busDadoEntrada;
   logic       memReq, memWrite, memAck;
   logic [5:0] memEndereco;
   logic [7:0] memDadoEscrita, memDadoLeitura;

   int n_checks = 0;
   int n_fails  = 0;

   controlador_snooping #(.INDEX_W(2), .TAG_W(4), .DATA_W(8)) dut (
      .clock(clock), .reset(reset),
      .cpuValid(cpuValid), .cpuReady(cpuReady), .cpuWrite(cpuWrite),
      .cpuEndereco(cpuEndereco), .cpuDadoEscrita(cpuDadoEscrita),
      .cpuDone(cpuDone), .cpuDadoLeitura(cpuDadoLeitura),
      .maquina(maquina), .op(op), .estadoAtual(estadoAtual), .entradaMaquina(entradaMaquina),
      .novoEstado(novoEstado), .saidaMaquina(saidaMaquina),
      .writeBack(writeBack), .abortAccessMemory(abortAccessMemory),
      .busReq(busReq), .busGrant(busGrant),
      .busValid(busValid), .busMsg(busMsg), .busEndereco(busEndereco),
      .snoopValid(snoopValid), .snoopMsg(snoopMsg), .snoopEndereco(snoopEndereco),
      .snoopAck(snoopAck),
      .busAbortOut(busAbortOut), .busDadoSaida(busDadoSaida),
      .busAbortIn(busAbortIn), .busDadoEntrada(busDadoEntrada),
      .memReq(memReq), .memWrite(memWrite), .memEndereco(memEndereco),
      .memDadoEscrita(memDadoEscrita), .memAck(memAck), .memDadoLeitura(memDadoLeitura)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // MSI machine: acting mode decodes op, reacting mode decodes the snooped message.
   always_comb begin
      novoEstado        = estadoAtual;
      saidaMaquina      = 2'b11;
      writeBack         = 1'b0;
      abortAccessMemory = 1'b0;
      if (!maquina) begin
         case (op)
            2'b00: ;
            2'b01: begin
               novoEstado   = 2'b10;
               saidaMaquina = 2'b01;
               writeBack    = (estadoAtual == 2'b01);
            end
            2'b10: begin
               novoEstado   = 2'b01;
               saidaMaquina = (estadoAtual == 2'b10) ? 2'b00 : 2'b11;
            end
            default: begin
               novoEstado   = 2'b01;
               saidaMaquina = 2'b10;
               writeBack    = (estadoAtual == 2'b01);
            end
         endcase
      end else begin
         case (estadoAtual)
            2'b01: begin
               abortAccessMemory = (entradaMaquina == 2'b01) || (entradaMaquina == 2'b10);
               novoEstado        = (entradaMaquina == 2'b01) ? 2'b10 : 2'b00;
            end
            2'b10:   novoEstado = (entradaMaquina == 2'b01) ? 2'b10 : 2'b00;
            default: ;
         endcase
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Returns once the selected output is high, or reports a timeout.
   task automatic wait_out(input string tag, input int sel, input int limit);
      logic v;
      for (int i = 0; i <= limit; i++) begin
         case (sel)
            0:       v = busReq;
            1:       v = memReq;
            default: v = cpuDone;
         endcase
         if (v) return;
         if (i < limit) tick();
      end
      check_eq(tag, 32'(0), 32'(1));
   endtask

   task automatic aceitar(input logic w, input logic [5:0] a, input logic [7:0] d);
      cpuValid       = 1'b1;
      cpuWrite       = w;
      cpuEndereco    = a;
      cpuDadoEscrita = d;
      tick();
      cpuValid = 1'b0;
   endtask

   task automatic check_reset_outs(input string tag);
      check_eq({tag, "_ctl"}, 32'({cpuDone, busReq, busValid, memReq, memWrite, busAbortOut,
                                   snoopAck, maquina}), 32'(0));
      check_eq({tag, "_msgs"}, 32'({busMsg, entradaMaquina, op}), 32'(6'b111100));
      check_eq({tag, "_data"}, 32'(cpuDadoLeitura | busDadoSaida | memDadoEscrita), 32'(0));
      check_eq({tag, "_addr"}, 32'(busEndereco | memEndereco), 32'(0));
   endtask

   initial begin
      reset = 1'b0; cpuValid = 1'b0; cpuWrite = 1'b0; cpuEndereco = '0; cpuDadoEscrita = '0;
      busGrant = 1'b0; snoopValid = 1'b0; snoopMsg = 2'b11; snoopEndereco = '0;
      busAbortIn = 1'b0; busDadoEntrada = '0; memAck = 1'b0; memDadoLeitura = '0;
      tick(); tick();
      check_reset_outs("rst");
      reset = 1'b1;
      tick();
      check_eq("rst_ready", 32'(cpuReady), 32'(1));

      // Cold read of 0x05
      aceitar(1'b0, 6'h05, 8'h00);
      check_eq("r1_op", 32'({op, estadoAtual}), 32'(4'b0100));
      tick();
      check_eq("r1_busreq", 32'(busReq), 32'(1));
      busGrant = 1'b1;
      tick();
      check_eq("r1_msg", 32'({busValid, busMsg, busEndereco}), 32'({1'b1, 2'b01, 6'h05}));
      tick();
      check_eq("r1_memrd", 32'({busValid, memReq, memWrite, memEndereco}),
               32'({1'b0, 1'b1, 1'b0, 6'h05}));
      tick();
      memAck = 1'b1; memDadoLeitura = 8'hA1;
      tick();
      wait_out("r1_done_timeout", 2, 3);
      memAck = 1'b0;
      check_eq("r1_data", 32'({cpuDone, cpuDadoLeitura}), 32'({1'b1, 8'hA1}));
      check_eq("r1_fim_busreq", 32'(busReq), 32'(0));
      busGrant = 1'b0;
      tick();
      check_eq("r1_ready", 32'(cpuReady), 32'(1));

      // Read hit 0x05: done exactly 2 cycles after accept
      aceitar(1'b0, 6'h05, 8'h00);
      check_eq("r2_op", 32'({op, estadoAtual}), 32'(4'b0010));
      tick();
      check_eq("r2_done", 32'({cpuDone, cpuDadoLeitura, busReq}), 32'({1'b1, 8'hA1, 1'b0}));
      tick();
      check_eq("r2_ready", 32'({cpuReady, cpuDone}), 32'(2'b10));

      // Write hit on shared line: invalidate only
      aceitar(1'b1, 6'h05, 8'h3C);
      check_eq("w1_op", 32'({op, estadoAtual}), 32'(4'b1010));
      tick();
      busGrant = 1'b1;
      tick();
      check_eq("w1_msg", 32'({busValid, busMsg}), 32'(3'b100));
      tick();
      check_eq("w1_done", 32'({cpuDone, cpuDadoLeitura, memReq}), 32'({1'b1, 8'h3C, 1'b0}));
      busGrant = 1'b0;
      tick();

      // Snoop readMiss on modified line: supply data, downgrade
      snoopValid = 1'b1; snoopMsg = 2'b01; snoopEndereco = 6'h05;
      #1;
      check_eq("s1_noready", 32'(cpuReady), 32'(0));
      tick();
      check_eq("s1_ack", 32'({snoopAck, maquina, estadoAtual, entradaMaquina}),
               32'({1'b1, 1'b1, 2'b01, 2'b01}));
      check_eq("s1_abort", 32'({busAbortOut, busDadoSaida}), 32'({1'b1, 8'h3C}));
      snoopValid = 1'b0;
      tick();
      aceitar(1'b0, 6'h05, 8'h00);
      check_eq("s1_state", 32'({op, estadoAtual}), 32'(4'b0010));
      tick();
      check_eq("s1_rd", 32'(cpuDadoLeitura), 32'(8'h3C));
      tick();
      // Re-own the line so the next miss must write it back
      aceitar(1'b1, 6'h05, 8'h3C);
      tick();
      busGrant = 1'b1;
      tick(); tick();
      busGrant = 1'b0;
      tick();

      // Write miss 0x15 evicting modified 0x05
      aceitar(1'b1, 6'h15, 8'h77);
      check_eq("w2_op", 32'({op, estadoAtual}), 32'(4'b1101));
      tick();
      busGrant = 1'b1;
      tick();
      check_eq("w2_wb", 32'({memReq, memWrite, memEndereco, memDadoEscrita}),
               32'({1'b1, 1'b1, 6'h05, 8'h3C}));
      memAck = 1'b1;
      tick();
      memAck = 1'b0;
      check_eq("w2_msg", 32'({busValid, busMsg, busEndereco, memReq}),
               32'({1'b1, 2'b10, 6'h15, 1'b0}));
      tick();
      check_eq("w2_rd", 32'({memReq, memWrite, memEndereco}), 32'({1'b1, 1'b0, 6'h15}));
      memAck = 1'b1; memDadoLeitura = 8'h55;
      tick();
      wait_out("w2_done_timeout", 2, 3);
      memAck = 1'b0;
      check_eq("w2_done", 32'(cpuDadoLeitura), 32'(8'h77));
      busGrant = 1'b0;
      tick();
      aceitar(1'b0, 6'h15, 8'h00);
      check_eq("w2_line", 32'({op, estadoAtual}), 32'(4'b0001));
      tick();
      check_eq("w2_rdback", 32'(cpuDadoLeitura), 32'(8'h77));
      tick();

      // Read 0x02 (tag matches an invalid line), snoop during bus wait, reset mid-read
      aceitar(1'b0, 6'h02, 8'h00);
      check_eq("m3_op", 32'(op), 32'(2'b01));
      tick();
      wait_out("m3_busreq_timeout", 0, 2);
      snoopValid = 1'b1; snoopMsg = 2'b10; snoopEndereco = 6'h01;
      #1;
      check_eq("m3_drop", 32'(busReq), 32'(0));
      tick();
      check_eq("m3_snoop", 32'({snoopAck, maquina, estadoAtual, busAbortOut}),
               32'({1'b1, 1'b1, 2'b00, 1'b0}));
      snoopValid = 1'b0;
      tick();
      check_eq("m3_reconsulta", 32'({maquina, op, estadoAtual}), 32'({1'b0, 2'b01, 2'b00}));
      tick();
      busGrant = 1'b1;
      tick();
      check_eq("m3_msg", 32'({busValid, busMsg, busEndereco}), 32'({1'b1, 2'b01, 6'h02}));
      tick();
      check_eq("m3_memreq", 32'(memReq), 32'(1));
      #2;
      reset = 1'b0;
      #1;
      check_reset_outs("m3_rst");
      busGrant = 1'b0;
      tick(); tick();
      reset = 1'b1;
      tick();
      aceitar(1'b0, 6'h15, 8'h00);
      check_eq("m3_cleared", 32'({op, estadoAtual}), 32'(4'b0100));

      // Other cache supplies data together with memAck: bus data wins
      tick();
      busGrant = 1'b1;
      tick(); tick();
      check_eq("ab_busreq", 32'(busReq), 32'(1));
      memAck = 1'b1; memDadoLeitura = 8'h11; busAbortIn = 1'b1; busDadoEntrada = 8'hBB;
      #1;
      check_eq("ab_memdrop", 32'(memReq), 32'(0));
      tick();
      wait_out("ab_done_timeout", 2, 3);
      memAck = 1'b0; busAbortIn = 1'b0;
      check_eq("ab_data", 32'(cpuDadoLeitura), 32'(8'hBB));
      busGrant = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
